// File: rtl/zpaq_ctx_hash_update.sv
// Order-1..NCTX context hash updater over a byte history, one shared multiplier, valid/ready on both sides.
// Latency NCTX+1 cycles per byte; ZPAQ_CTX_POS_SALT_EN salts the order-1 hash with the record position.
module zpaq_ctx_hash_update #(
  parameter int IN_DW  = 8,
  parameter int H_DW   = 32,
  parameter int NCTX   = 4,
  parameter int HMUL   = 773,
  parameter int HADD   = 512,
  parameter int POS_DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_DW-1:0]     Byte,
  input  logic                 InputLast,
  input  logic                 InputValid,
  output logic                 InputReady,
  output logic [NCTX*H_DW-1:0] h,
  output logic [POS_DW-1:0]    pos,
  output logic                 OutputValid,
  input  logic                 OutputReady,
  output logic                 UpdateFinish
);

  localparam int KW = (NCTX > 1) ? $clog2(NCTX) : 1;

  typedef enum logic [1:0] {IDLE, HASH, OUT} state_t;

  state_t           state, stateNext;
  logic [IN_DW-1:0] hist [NCTX];
  logic [H_DW-1:0]  hReg [NCTX];
  logic [KW-1:0]    k, kPrev;
  logic             lastQ;
  logic             accept, handshake, kDone;
  logic [H_DW-1:0]  prevH, acc, hNext;

  assign accept       = InputValid & InputReady;
  assign handshake    = OutputValid & OutputReady;
  assign UpdateFinish = handshake;
  assign kDone        = (k == KW'(NCTX - 1));

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    InputReady  = 1'b0;
    OutputValid = 1'b0;
    case (state)
      IDLE: begin
        InputReady = 1'b1;
        if (InputValid) stateNext = HASH;
      end
      HASH: if (kDone) stateNext = OUT;
      OUT: begin
        OutputValid = 1'b1;
        if (OutputReady) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Each HASH cycle chains the previous order's hash into the next one.
  always_comb begin
    kPrev = (k == '0) ? '0 : k - 1'b1;
    prevH = (k == '0) ? '0 : hReg[kPrev];
    acc   = prevH + H_DW'(hist[k]) + H_DW'(HADD);
`ifdef ZPAQ_CTX_POS_SALT_EN
    if (k == '0) acc = acc + H_DW'(pos);
`endif
    hNext = acc * H_DW'(HMUL);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < NCTX; j++) begin
        hist[j] <= '0;
        hReg[j] <= '0;
      end
      k     <= '0;
      lastQ <= 1'b0;
      pos   <= '0;
    end else begin
      if (accept) begin
        for (int j = NCTX - 1; j > 0; j--) hist[j] <= hist[j-1];
        hist[0] <= Byte;
        lastQ   <= InputLast;
        k       <= '0;
      end
      if (state == HASH) begin
        hReg[k] <= hNext;
        if (!kDone) k <= k + 1'b1;
      end
      // A record end restarts both the history and the position count.
      if (handshake) begin
        if (lastQ) begin
          for (int j = 0; j < NCTX; j++) hist[j] <= '0;
          pos <= '0;
        end else if (pos != '1) begin
          pos <= pos + 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < NCTX; i++) begin : g_pack
    assign h[i*H_DW +: H_DW] = hReg[i];
  end

endmodule
